// File: rtl/can_id_gen_pkg.sv
// Shared types and constants for the CAN ID traffic generator.
package can_id_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_EMIT,
        S_GAP
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Bits of LFSR state needed to index a population of popsize IDs.
    function automatic int idx_width(input int popsize);
        return (popsize <= 2) ? 1 : $clog2(popsize);
    endfunction

endpackage

// File: rtl/can_id_gen_lfsr.sv
// 16-bit right-shifting Galois LFSR; seed loads on reset, steps when adv is high.
// next_value is the state the register takes on the next advance.
module can_id_gen_lfsr
    import can_id_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [15:0] next_value
);

    logic [15:0] value;
    logic [15:0] seed_eff;

    // An all-zero state would lock the LFSR up.
    assign seed_eff   = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    assign next_value = value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= seed_eff;
        end else if (adv) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/can_id_gen.sv
// CAN ID traffic source: one ID per data_rdy pulse, pseudo-random normal IDs plus periodic attack IDs.
// First pulse two cycles after start at the earliest; CAN_ID_GEN_BURST_EN adds a frame_limit input.
module can_id_gen
    import can_id_gen_pkg::*;
#(
    parameter int ID_WIDTH      = 11,
    parameter int POPSIZE       = 100,
    parameter int BASE_ID       = 'h100,
    parameter int GAP           = 4,
    parameter int ATTACK_ID     = 'h000,
    parameter int ATTACK_PERIOD = 4,
    parameter int LFSR_SEED     = 'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                attack_en,
`ifdef CAN_ID_GEN_BURST_EN
    input  logic [15:0]         frame_limit,
`endif
    output logic [ID_WIDTH-1:0] ID_out,
    output logic                data_rdy,
    output logic                attack_flag,
    output logic                busy,
    output logic [15:0]         frame_cnt
);

    localparam int                IDX_W    = idx_width(POPSIZE);
    localparam logic [15:0]       IDX_MASK = 16'((1 << IDX_W) - 1);
    localparam logic [15:0]       POP16    = 16'(POPSIZE);
    localparam logic [ID_WIDTH-1:0] BASE_V   = ID_WIDTH'(BASE_ID);
    localparam logic [ID_WIDTH-1:0] ATTACK_V = ID_WIDTH'(ATTACK_ID);
    localparam logic [15:0]       PER_LAST = 16'(ATTACK_PERIOD - 1);
    localparam logic [15:0]       GAP_LAST = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

    state_t      state;
    logic [15:0] per_cnt;
    logic [15:0] gap_cnt;
    logic        stop_pend;
    logic [15:0] lfsr_next;
    logic [15:0] cand;
    logic        attack_slot;
    logic        lfsr_adv;
    logic        stop_now;
    logic        limit_hit;

    assign cand        = lfsr_next & IDX_MASK;
    assign attack_slot = attack_en && (per_cnt == PER_LAST);
    // Every non-attack DRAW cycle consumes one LFSR step, accepted or not.
    assign lfsr_adv    = (state == S_DRAW) && !attack_slot;
    assign stop_now    = stop || stop_pend;

`ifdef CAN_ID_GEN_BURST_EN
    assign limit_hit = (frame_limit != 16'd0) && ((frame_cnt + 16'd1) == frame_limit);
`else
    assign limit_hit = 1'b0;
`endif

    can_id_gen_lfsr u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .seed       (16'(LFSR_SEED)),
        .adv        (lfsr_adv),
        .next_value (lfsr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ID_out      <= '0;
            data_rdy    <= 1'b0;
            attack_flag <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= 16'd0;
            per_cnt     <= 16'd0;
            gap_cnt     <= 16'd0;
            stop_pend   <= 1'b0;
        end else begin
            data_rdy    <= 1'b0;
            attack_flag <= 1'b0;
            if ((state != S_IDLE) && stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state     <= S_DRAW;
                        busy      <= 1'b1;
                        frame_cnt <= 16'd0;
                        per_cnt   <= 16'd0;
                        stop_pend <= 1'b0;
                    end
                end
                S_DRAW: begin
                    if (attack_slot) begin
                        ID_out      <= ATTACK_V;
                        attack_flag <= 1'b1;
                        data_rdy    <= 1'b1;
                        state       <= S_EMIT;
                    end else if (cand < POP16) begin
                        ID_out   <= BASE_V + ID_WIDTH'(cand);
                        data_rdy <= 1'b1;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    per_cnt   <= (per_cnt == PER_LAST) ? 16'd0 : per_cnt + 16'd1;
                    gap_cnt   <= 16'd0;
                    if (limit_hit) begin
                        stop_pend <= 1'b1;
                    end
                    if (GAP > 0) begin
                        state <= S_GAP;
                    end else if (stop_now || limit_hit) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_DRAW;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                    if (gap_cnt == GAP_LAST) begin
                        if (stop_now) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DRAW;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_id_gen.sv
// Bench for can_id_gen: two instances (GAP=4/POPSIZE=100 and GAP=0/POPSIZE=128) against a frame-level model.
module tb_can_id_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        stop  [2];
    logic        aen   [2];
    logic [10:0] id_o  [2];
    logic        dr    [2];
    logic        af    [2];
    logic        bz    [2];
    logic [15:0] fc    [2];
`ifdef CAN_ID_GEN_BURST_EN
    logic [15:0] flim  [2] = '{16'd0, 16'd0};
`endif

    always #5 clk = ~clk;

    can_id_gen #(.ID_WIDTH(11), .POPSIZE(100), .BASE_ID('h100), .GAP(4),
                 .ATTACK_ID('h000), .ATTACK_PERIOD(4), .LFSR_SEED('hACE1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .attack_en(aen[0]),
`ifdef CAN_ID_GEN_BURST_EN
        .frame_limit(flim[0]),
`endif
        .ID_out(id_o[0]), .data_rdy(dr[0]), .attack_flag(af[0]), .busy(bz[0]), .frame_cnt(fc[0])
    );

    can_id_gen #(.ID_WIDTH(11), .POPSIZE(128), .BASE_ID('h100), .GAP(0),
                 .ATTACK_ID('h000), .ATTACK_PERIOD(4), .LFSR_SEED('hACE1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .attack_en(aen[1]),
`ifdef CAN_ID_GEN_BURST_EN
        .frame_limit(flim[1]),
`endif
        .ID_out(id_o[1]), .data_rdy(dr[1]), .attack_flag(af[1]), .busy(bz[1]), .frame_cnt(fc[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state; all times are posedge numbers (cyc as seen at the following negedge).
    int          m_run  [2] = '{0, 0};
    int          m_next [2] = '{-1, -1};
    int          m_from [2] = '{0, 0};
    int          m_last [2] = '{-100, -100};
    int          m_end  [2] = '{-1, -1};
    int          m_n    [2] = '{0, 0};
    int          m_stop [2] = '{0, 0};
    int          pcnt   [2] = '{0, 0};
    logic [15:0] m_lfsr [2] = '{16'hACE1, 16'hACE1};
    logic [15:0] m_lfsr_p [2] = '{16'hACE1, 16'hACE1};
    logic [10:0] m_id   [2] = '{11'd0, 11'd0};
    logic        m_flag [2] = '{1'b0, 1'b0};
    bit          m_rchk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gap_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic int pop_of(input int d);
        return (d == 0) ? 100 : 128;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Step the LFSR until its low bits index inside the population.
    function automatic void draw(input int pop, input logic [15:0] s_in,
                                 output logic [15:0] s_out, output int val, output int rej);
        logic [15:0] s;
        int          w;
        s   = s_in;
        w   = $clog2(pop);
        rej = 0;
        val = -1;
        for (int i = 0; i < 4096; i++) begin
            s = lstep(s);
            if ((int'(s) % (1 << w)) < pop) begin
                val = int'(s) % (1 << w);
                break;
            end
            rej++;
        end
        s_out = s;
    endfunction

    function automatic bit limit_reached(input int d);
`ifdef CAN_ID_GEN_BURST_EN
        return (flim[d] != 16'd0) && (m_n[d] == int'(flim[d]));
`else
        return (d < 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict the next frame whose DRAW begins after posedge 'from'.
    task automatic plan(input int d, input int from);
        int          val;
        int          rej;
        logic [15:0] s;
        if (aen[d] && (((m_n[d] + 1) % 4) == 0)) begin
            m_id[d]     = 11'h000;
            m_flag[d]   = 1'b1;
            m_lfsr_p[d] = m_lfsr[d];
            rej         = 0;
        end else begin
            draw(pop_of(d), m_lfsr[d], s, val, rej);
            m_lfsr_p[d] = s;
            m_id[d]     = 11'('h100 + val);
            m_flag[d]   = 1'b0;
        end
        m_from[d] = from;
        m_next[d] = from + 1 + rej;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_rchk) begin
                chk("rst_data_rdy", 32'(dr[d]), 0);
                chk("rst_id", 32'(id_o[d]), 0);
                chk("rst_attack_flag", 32'(af[d]), 0);
                chk("rst_busy", 32'(bz[d]), 0);
                chk("rst_frame_cnt", 32'(fc[d]), 0);
            end else if (m_run[d] != 0) begin
                if (cyc == m_next[d]) begin
                    chk("data_rdy", 32'(dr[d]), 1);
                    chk("id", 32'(id_o[d]), 32'(m_id[d]));
                    chk("attack_flag", 32'(af[d]), 32'(m_flag[d]));
                    if (d == 0 && !m_flag[d])
                        chk("id_in_range", 32'(id_o[d] >= 11'h100 && id_o[d] <= 11'h163), 1);
                    m_n[d]++;
                    m_last[d] = cyc;
                    m_lfsr[d] = m_lfsr_p[d];
                    m_next[d] = -1;
                    if (m_stop[d] != 0 || limit_reached(d))
                        m_end[d] = cyc + gap_of(d) + 1;
                    else
                        plan(d, cyc + gap_of(d) + 1);
                end else begin
                    chk("data_rdy_between", 32'(dr[d]), 0);
                    chk("attack_flag_between", 32'(af[d]), 0);
                end
                if (cyc == m_last[d] + 1)
                    chk("frame_cnt", 32'(fc[d]), 32'(m_n[d] % 65536));
                chk("busy", 32'(bz[d]), 32'(m_end[d] < 0 || cyc < m_end[d]));
                if (cyc == m_end[d])
                    m_run[d] = 0;
            end else begin
                chk("idle_data_rdy", 32'(dr[d]), 0);
                chk("idle_busy", 32'(bz[d]), 0);
            end
            if (dr[d] === 1'b1)
                pcnt[d]++;

            if (rst) begin
                m_run[d]  = 0;
                m_next[d] = -1;
                m_end[d]  = -1;
                m_last[d] = -100;
                m_n[d]    = 0;
                m_stop[d] = 0;
                m_lfsr[d] = 16'hACE1;
            end else if (m_run[d] == 0 && start[d] && !stop[d]) begin
                m_run[d]  = 1;
                m_n[d]    = 0;
                m_stop[d] = 0;
                m_end[d]  = -1;
                m_last[d] = -100;
                plan(d, cyc + 1);
            end else if (m_run[d] != 0 && stop[d] && m_end[d] < 0) begin
                if (m_next[d] >= 0 && (cyc + 1) <= m_from[d]) begin
                    m_next[d] = -1;
                    m_end[d]  = m_from[d];
                end else begin
                    m_stop[d] = 1;
                end
            end
        end
        m_rchk = rst;
    end

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic pulse_stop(input int d);
        stop[d] = 1'b1;
        @(posedge clk); #1;
        stop[d] = 1'b0;
    endtask

    task automatic wait_pulses(input int d, input int target, input int lim);
        int t;
        t = 0;
        while (pcnt[d] < target && t < lim) begin
            @(posedge clk); #1;
            t++;
        end
        if (pcnt[d] < target) begin
            total++;
            bad++;
            $display("FAIL wait_pulses dut%0d: got %0d pulses want %0d", d, pcnt[d], target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        int          v;
        int          r;
        int          p0;
        int          q;
        bit          seen;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            stop[d]  = 1'b0;
            aen[d]   = 1'b0;
        end

        // Hand-worked LFSR steps from seed ACE1: E270, 7138, ...
        chk("pin_lstep", 32'(lstep(16'hACE1)), 32'hE270);
        draw(100, 16'hACE1, s, v, r);
        chk("pin_pop100_val", 32'(v), 32'h38);
        chk("pin_pop100_rej", 32'(r), 1);
        draw(128, 16'hACE1, s, v, r);
        chk("pin_pop128_val", 32'(v), 32'h70);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Normal traffic, stopped in the GAP after frame 5.
        p0 = pcnt[0];
        pulse_start(0);
        wait_pulses(0, p0 + 1, 50);
        chk("first_id_dut0", 32'(id_o[0]), 32'h138);
        wait_pulses(0, p0 + 5, 200);
        pulse_stop(0);
        repeat (8) @(posedge clk);
        #1;
        chk("stop_busy", 32'(bz[0]), 0);
        chk("stop_frame_cnt", 32'(fc[0]), 5);
        chk("stop_pulses", 32'(pcnt[0] - p0), 5);

        // Attack injection on every 4th frame.
        aen[0] = 1'b1;
        p0 = pcnt[0];
        pulse_start(0);
        wait_pulses(0, p0 + 4, 200);
        chk("attack_id_f4", 32'(id_o[0]), 32'h000);
        wait_pulses(0, p0 + 12, 300);
        pulse_stop(0);
        repeat (8) @(posedge clk);
        #1;
        chk("attack_run_busy", 32'(bz[0]), 0);
        chk("attack_run_frame_cnt", 32'(fc[0]), 12);
        aen[0] = 1'b0;

        // GAP=0, power-of-two population: a pulse every other cycle.
        p0 = pcnt[1];
        pulse_start(1);
        wait_pulses(1, p0 + 1, 10);
        chk("first_id_dut1", 32'(id_o[1]), 32'h170);
        q = pcnt[1];
        repeat (20) @(posedge clk);
        #1;
        chk("dut1_rate", 32'(pcnt[1] - q), 10);
        pulse_stop(1);
        repeat (4) @(posedge clk);
        #1;
        chk("dut1_stop_busy", 32'(bz[1]), 0);

        // Reset landing on an EMIT cycle.
        pulse_start(0);
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            if (dr[0] === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rst_emit_seen", 32'(seen), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_emit_data_rdy", 32'(dr[0]), 0);
        chk("rst_emit_frame_cnt", 32'(fc[0]), 0);
        repeat (3) @(posedge clk);
        #1;

`ifdef CAN_ID_GEN_BURST_EN
        flim[0] = 16'd10;
        p0 = pcnt[0];
        pulse_start(0);
        wait_pulses(0, p0 + 10, 400);
        repeat (20) @(posedge clk);
        #1;
        chk("burst_pulses", 32'(pcnt[0] - p0), 10);
        chk("burst_busy", 32'(bz[0]), 0);
        chk("burst_frame_cnt", 32'(fc[0]), 10);
        flim[0] = 16'd0;
`endif

        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
